// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude compare sequencer: scans two latched operands MSB first
// through an external 1-bit comparator cell and reports eq/gt/lt/err with a done pulse.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_fa,
  input  logic             cmp_fb,
  input  logic             cmp_fc,
  input  logic             cmp_fd,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             err,
  output logic [IDXW:0]    nbits
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDXW-1:0]  idx;
  logic [IDXW:0]    cnt;

  logic [1:0] hot;
  logic       cell_bad;
  logic       scan_fin;

  // Cell operands come straight from the registers so the cell answers in the same cycle.
  assign cmp_a = (state == SCAN) & a_r[idx];
  assign cmp_b = (state == SCAN) & b_r[idx];

  // A healthy cell has fb == ~fa and exactly one of eq/gt/lt set.
  assign hot      = {1'b0, cmp_fa} + {1'b0, cmp_fc} + {1'b0, cmp_fd};
  assign cell_bad = (cmp_fb == cmp_fa) | (hot != 2'd1);
  assign scan_fin = cell_bad | ~cmp_fa | (idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      err   <= 1'b0;
      nbits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            idx   <= IDXW'(WIDTH - 1);
            cnt   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          cnt <= cnt + 1'b1;
          if (cell_bad) begin
            err <= 1'b1;
            eq  <= 1'b0;
            gt  <= 1'b0;
            lt  <= 1'b0;
          end else if (cmp_fc) begin
            gt <= 1'b1;
          end else if (cmp_fd) begin
            lt <= 1'b1;
          end else if (idx == '0) begin
            eq <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
          if (scan_fin) begin
            nbits <= cnt + 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl with a behavioural 1-bit comparator cell and fault injection.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cmp_a, cmp_b;
  logic             cmp_fa, cmp_fb, cmp_fc, cmp_fd;
  logic             busy, done, eq, gt, lt, err;
  logic [IDXW:0]    nbits;
  logic             fault;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  serial_cmp_ctrl #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_fa(cmp_fa), .cmp_fb(cmp_fb), .cmp_fc(cmp_fc), .cmp_fd(cmp_fd),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt), .err(err), .nbits(nbits)
  );

  always #5 clk = ~clk;

  // Behavioural cell; fault forces the inconsistent fa=1, fb=1 pattern.
  always_comb begin
    cmp_fa = (cmp_a == cmp_b);
    cmp_fb = (cmp_a != cmp_b);
    cmp_fc = cmp_a & ~cmp_b;
    cmp_fd = ~cmp_a & cmp_b;
    if (fault) begin
      cmp_fa = 1'b1;
      cmp_fb = 1'b1;
      cmp_fc = 1'b0;
      cmp_fd = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start and counts edges after acceptance until done is seen.
  task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, output int cyc);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; fault = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_cnt++;
    if ({cmp_a, cmp_b, busy, done, eq, gt, lt, err, nbits} !== '0)
      $display("FAIL reset_outputs got=%b exp=0", {cmp_a, cmp_b, busy, done, eq, gt, lt, err, nbits});
    else pass_cnt++;
  endtask

  task automatic test_equal();
    logic [WIDTH-1:0] av;
    int busy_n;
    av = 8'hA5;
    a = av; b = av; start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = 0;
    for (int i = WIDTH - 1; i >= 0 && busy && busy_n < 20; i--) begin
      chk_cnt++;
      if (cmp_a !== av[i] || cmp_b !== av[i])
        $display("FAIL eq_cmp_bits bit=%0d got=%b%b exp=%b%b", i, cmp_a, cmp_b, av[i], av[i]);
      else pass_cnt++;
      tick();
      busy_n++;
    end
    chk_cnt++;
    if (busy_n !== 8) $display("FAIL eq_busy_cycles got=%0d exp=8", busy_n);
    else pass_cnt++;
    chk_cnt++;
    if ({done, busy, eq, gt, lt, err, nbits} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8})
      $display("FAIL eq_result got=%b exp=%b", {done, busy, eq, gt, lt, err, nbits},
               {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({done, cmp_a, cmp_b} !== 3'b000) $display("FAIL eq_done_pulse got=%b exp=000", {done, cmp_a, cmp_b});
    else pass_cnt++;
  endtask

  task automatic test_gt_lt();
    int cyc;
    run_cmp(8'h80, 8'h7F, cyc);
    chk_cnt++;
    if (cyc !== 1) $display("FAIL gt_latency got=%0d exp=1", cyc);
    else pass_cnt++;
    chk_cnt++;
    if ({eq, gt, lt, err, nbits} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd1})
      $display("FAIL gt_result got=%b exp=%b", {eq, gt, lt, err, nbits}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd1});
    else pass_cnt++;
    tick();
    run_cmp(8'h12, 8'h13, cyc);
    chk_cnt++;
    if (cyc !== 8) $display("FAIL lt_latency got=%0d exp=8", cyc);
    else pass_cnt++;
    chk_cnt++;
    if ({eq, gt, lt, err, nbits} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd8})
      $display("FAIL lt_result got=%b exp=%b", {eq, gt, lt, err, nbits}, {1'b0, 1'b0, 1'b1, 1'b0, 4'd8});
    else pass_cnt++;
    tick();
    run_cmp(8'h34, 8'h24, cyc);
    chk_cnt++;
    if (cyc !== 4 || {eq, gt, lt, nbits} !== {1'b0, 1'b1, 1'b0, 4'd4})
      $display("FAIL gt_bit4 got=%0d/%b exp=4/%b", cyc, {eq, gt, lt, nbits}, {1'b0, 1'b1, 1'b0, 4'd4});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    a = 8'h00; b = 8'hFF; start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk_cnt++;
      if ({busy, done} !== 2'b10) $display("FAIL b2b_scan[%0d] got=%b exp=10", i, {busy, done});
      else pass_cnt++;
      a = 8'hFF; b = 8'h00;
      tick();
      chk_cnt++;
      if ({done, busy, eq, gt, lt, nbits} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1})
        $display("FAIL b2b_done[%0d] got=%b exp=%b", i, {done, busy, eq, gt, lt, nbits},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1});
      else pass_cnt++;
      a = 8'h00; b = 8'hFF;
      tick();
    end
    start = 1'b0;
    tick(); tick(); tick();
    chk_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL b2b_drain got=%b exp=00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    int seen_done;
    a = 8'h01; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if ({cmp_a, cmp_b, busy, done, eq, gt, lt, err, nbits} !== '0)
      $display("FAIL midrst_outputs got=%b exp=0", {cmp_a, cmp_b, busy, done, eq, gt, lt, err, nbits});
    else pass_cnt++;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk_cnt++;
    if (seen_done !== 0) $display("FAIL midrst_idle got=%0d exp=0", seen_done);
    else pass_cnt++;
    run_cmp(8'h01, 8'h00, cyc);
    chk_cnt++;
    if (cyc !== 8 || {eq, gt, lt, err, nbits} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd8})
      $display("FAIL midrst_rerun got=%0d/%b exp=8/%b", cyc, {eq, gt, lt, err, nbits},
               {1'b0, 1'b1, 1'b0, 1'b0, 4'd8});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_cell_fault();
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chk_cnt++;
    if ({done, err, eq, gt, lt, nbits} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3})
      $display("FAIL fault_result got=%b exp=%b", {done, err, eq, gt, lt, nbits},
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_hold();
    int cyc;
    run_cmp(8'h12, 8'h13, cyc);
    a = 8'hFF; b = 8'h00;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk_cnt++;
      if ({eq, gt, lt, err, nbits, done, busy} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0})
        $display("FAIL hold[%0d] got=%b exp=%b", i, {eq, gt, lt, err, nbits, done, busy},
                 {1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0});
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_lt();
    test_back_to_back();
    test_reset_mid_scan();
    test_cell_fault();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
